// File: rtl/dac_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dac_sample_scheduler
// Brief    : Sample FIFO plus divider-paced DAC strobe sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module dac_sample_scheduler #(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  div,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_en,
  output logic              busy,
  output logic              underrun
);

  localparam int                c_AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                c_CW       = c_AW + 1;
  localparam logic [c_CW-1:0]   c_FULL     = c_CW'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] c_MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]     r_wr_ptr;
  logic [c_AW-1:0]     r_rd_ptr;
  logic [c_CW-1:0]     r_count;

  logic [DIV_W-1:0]    r_div_q;
  logic [DIV_W-1:0]    r_tick;
  logic [DATA_W-1:0]   r_dac_data;
  logic                r_dac_en;
  logic                r_busy;
  logic                r_underrun;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_active;
  logic                w_tick;
  logic                w_pop;
  logic                w_starve;
  logic                w_start_ok;

  assign w_full     = (r_count == c_FULL);
  assign w_empty    = (r_count == '0);
  assign w_push     = s_valid && !w_full;
  assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_tick     = w_active && (r_tick == r_div_q);
  assign w_pop      = w_tick && !w_empty;
  assign w_starve   = w_tick && w_empty;
  assign w_start_ok = (r_state == S_IDLE) && start;

  // stop has priority over start outside IDLE simply because start is only
  // decoded in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = w_full ? S_RUN : S_PRIME;
        end
      end
      S_PRIME: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_full) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_tick && (r_count <= c_CW'(1))) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The tick counter idles at zero so RUN always starts a fresh period; it
  // keeps running across the RUN->DRAIN transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick <= '0;
    end else if (w_active) begin
      r_tick <= w_tick ? '0 : r_tick + DIV_W'(1);
    end else begin
      r_tick <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_q <= '0;
    end else if (w_start_ok) begin
      r_div_q <= div;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dac_data <= c_MIDSCALE;
      r_dac_en   <= 1'b0;
    end else begin
      r_dac_en <= w_pop;
      if (w_pop) begin
        r_dac_data <= r_mem[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_underrun <= 1'b0;
    end else if (w_start_ok) begin
      r_underrun <= 1'b0;
    end else if ((r_state == S_RUN) && w_starve) begin
      r_underrun <= 1'b1;
    end
  end

  assign s_ready  = !w_full;
  assign dac_data = r_dac_data;
  assign dac_en   = r_dac_en;
  assign busy     = r_busy;
  assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_sample_scheduler
// Brief    : Directed scoreboard bench for dac_sample_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_sample_scheduler;

  localparam int DATA_W     = 12;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic [DIV_W-1:0]  div;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] dac_data;
  logic              dac_en;
  logic              busy;
  logic              underrun;

  dac_sample_scheduler #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_W     (DIV_W)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .div     (div),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .dac_data(dac_data),
    .dac_en  (dac_en),
    .busy    (busy),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic expect_sample(input logic [DATA_W-1:0] d, input int at);
    exp_t e;
    e.data = d;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int max_cycles);
    int k = 0;
    while (sb.size() != 0 && k < max_cycles) begin
      step();
      k++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  // at < 0 means only the value and order are checked, not the cycle.
  always @(negedge clk) begin
    if (dac_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_dac_en: strobe with data 0x%0h at cycle %0d, expected none", dac_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("dac_data", dac_data, mon_e.data);
        if (mon_e.at >= 0) check("dac_en_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  logic [DATA_W-1:0] t2 [4];
  logic [DATA_W-1:0] v;
  int entry, max_low, low_run, en_gaps, en_seen;
  logic pushed, seen;

  initial begin
    t2[0] = 12'h000; t2[1] = 12'h400; t2[2] = 12'h800; t2[3] = 12'hFFF;
    rst = 1'b1; start = 1'b0; stop = 1'b0; div = '0; s_data = '0; s_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // 1: reset / idle values
    check("rst_dac_data", dac_data, 12'h800);
    check("rst_dac_en", dac_en, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_underrun", underrun, 0);

    // 2: prefill in IDLE, start with div=3 -> RUN next cycle, strobe every 4
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = t2[i];
      step();
    end
    s_valid = 1'b0;
    check("prefill_full", s_ready, 0);
    start = 1'b1; div = 16'd3;
    entry = cyc + 1;
    for (int i = 0; i < 4; i++) expect_sample(t2[i], entry + 4 * (i + 1));
    step();
    start = 1'b0;
    check("t2_busy", busy, 1);
    step_to(entry + 17);
    check("t2_no_extra_en", dac_en, 0);
    wait_drain(4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step_to(entry + 22);
    check("t2_idle_after_drain", busy, 0);
    check("t2_no_underrun_in_drain", underrun, 0);
    check("t2_hold_last", dac_data, 12'hFFF);

    // 3: continuous 12-bit ramp (wrapping), div=0
    start = 1'b1; div = 16'd0;
    step();
    start = 1'b0;
    v = 12'hFFC; seen = 1'b0; max_low = 0; low_run = 0; en_gaps = 0;
    s_valid = 1'b1; s_data = v;
    repeat (40) begin
      pushed = s_ready;
      if (seen) begin
        if (!dac_en) en_gaps++;
        if (!s_ready) low_run++; else low_run = 0;
        if (low_run > max_low) max_low = low_run;
      end
      if (dac_en) seen = 1'b1;
      if (pushed) expect_sample(v, -1);
      step();
      if (pushed) v = v + 12'd1;
      s_data = v;
    end
    s_valid = 1'b0;
    check("t3_strobes_started", seen, 1);
    check("t3_en_every_cycle_gaps", en_gaps, 0);
    check("t3_s_ready_low_over_1", (max_low > 1), 0);
    check("t3_underrun", underrun, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_drain(20);
    repeat (2) step();
    check("t3_idle", busy, 0);

    // 4: div=1, four samples then starvation
    start = 1'b1; div = 16'd1;
    step();
    start = 1'b0;
    check("t4_prime_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 12'(12'h111 * (i + 1));
      step();
    end
    s_valid = 1'b0;
    entry = cyc + 1;
    for (int i = 0; i < 4; i++) expect_sample(12'(12'h111 * (i + 1)), entry + 2 * (i + 1));
    step_to(entry + 9);
    check("t4_underrun_before_5th", underrun, 0);
    step();
    check("t4_underrun_5th", underrun, 1);
    check("t4_no_en_5th", dac_en, 0);
    check("t4_hold_4th", dac_data, 12'h444);
    check("t4_still_run", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (4) step();
    check("t4_idle", busy, 0);
    check("t4_underrun_sticky", underrun, 1);

    // 5: new start clears underrun; stop in RUN with 3 queued, div=2
    start = 1'b1; div = 16'd2;
    step();
    start = 1'b0;
    check("t5_start_clears_underrun", underrun, 0);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 12'(12'hA01 + i);
      step();
    end
    s_valid = 1'b0;
    entry = cyc + 1;
    for (int i = 0; i < 4; i++) expect_sample(12'(12'hA01 + i), entry + 3 * (i + 1));
    step_to(entry + 3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step_to(entry + 11);
    check("t5_busy_before_last", busy, 1);
    step();
    check("t5_idle_on_last", busy, 0);
    step();
    check("t5_hold_last", dac_data, 12'hA04);
    check("t5_no_en_idle", dac_en, 0);
    start = 1'b1; stop = 1'b1; div = 16'd7;
    step();
    check("t5_idle_start_wins", busy, 1);
    step();
    start = 1'b0; stop = 1'b0;
    check("t5_prime_stop_wins", busy, 0);
    repeat (2) step();
    check("t5_stays_idle", busy, 0);

    // 6: reset mid-RUN with 2 queued, then restart from empty FIFO
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 12'(12'hB01 + i);
      step();
    end
    s_valid = 1'b0;
    start = 1'b1; div = 16'd1;
    entry = cyc + 1;
    expect_sample(12'hB01, entry + 2);
    expect_sample(12'hB02, entry + 4);
    step();
    start = 1'b0;
    step_to(entry + 4);
    rst = 1'b1;
    step();
    check("t6_rst_dac_data", dac_data, 12'h800);
    check("t6_rst_dac_en", dac_en, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_s_ready", s_ready, 1);
    rst = 1'b0;
    start = 1'b1; div = 16'd0;
    step();
    start = 1'b0;
    en_seen = 0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 12'(12'hC01 + i);
      step();
      s_valid = 1'b0;
      repeat (2) begin
        if (dac_en) en_seen++;
        step();
      end
    end
    check("t6_prime_no_en", en_seen, 0);
    check("t6_prime_busy", busy, 1);
    s_valid = 1'b1; s_data = 12'hC04;
    step();
    s_valid = 1'b0;
    entry = cyc + 1;
    for (int i = 0; i < 4; i++) expect_sample(12'(12'hC01 + i), entry + 1 + i);
    wait_drain(10);
    repeat (3) step();
    check("t6_underrun_after_empty", underrun, 1);

    rst = 1'b1;
    repeat (2) step();
    check("end_scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dac_sample_scheduler.md
Name: dac_sample_scheduler

Overview:
Sequencer for the 12-bit DAC in the sine-wave path. Buffers samples from an upstream generator (such as a sine LUT or NCO) in a small FIFO using a valid/ready handshake. Presents one sample to the DAC every div+1 clock cycles on dac_data, with a one-cycle dac_en strobe. Provides start/stop control, prime and drain phases, and sticky underrun detection.

Parameters:
DATA_W, 12, sample width; matches DAC input width.
FIFO_DEPTH, 4, sample FIFO entries; must be a power of two, 2 or greater.
DIV_W, 16, width of the sample-period divider.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous active-high reset.
start  in  1  single-cycle pulse; begins playback from IDLE.
stop  in  1  single-cycle pulse; ends playback.
div  in  DIV_W  sample period minus 1, in clk cycles; sampled only when start is accepted.
s_data  in  DATA_W  upstream sample.
s_valid  in  1  upstream sample valid.
s_ready  out  1  FIFO can accept a sample.
dac_data  out  DATA_W  code to the DAC I_data input.
dac_en  out  1  one-cycle strobe to the DAC en input.
busy  out  1  high when state is not IDLE.
underrun  out  1  sticky; a sample tick found the FIFO empty.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE; FIFO emptied (count 0).
  - dac_data = 12'h800 (midscale); dac_en = 0; busy = 0; underrun = 0.
  - Tick counter = 0; div_q = 0.
  - A reset asserted mid-operation aborts immediately to these values.
- All outputs are registered.
- s_ready = (count != FIFO_DEPTH), computed from registered count, in every state.
- A push occurs when s_valid && s_ready. Push and pop in the same cycle leave count unchanged. Order is FIFO; pointers wrap modulo FIFO_DEPTH.
- States:
  - IDLE:
    - When start is seen, latch div_q <= div and clear underrun.
    - Go to RUN if count == FIFO_DEPTH, otherwise to PRIME.
    - stop is ignored in IDLE. The FIFO may be prefilled while IDLE.
  - PRIME:
    - Wait until count == FIFO_DEPTH, then go to RUN.
    - stop returns to IDLE and keeps the FIFO contents.
  - RUN:
    - The tick counter resets to 0 on entry. It increments each cycle.
    - When the counter equals div_q, a tick fires and the counter returns to 0. The first tick is therefore div_q+1 cycles after entry. With div_q = 0 there is a tick every cycle.
    - On a tick with count > 0: pop the FIFO head into dac_data and set dac_en = 1 on the same edge.
    - On a tick with count == 0: dac_data holds, dac_en stays 0, and underrun <= 1.
    - stop moves to DRAIN. The counter is not reset.
  - DRAIN:
    - Ticks continue exactly as in RUN.
    - When a tick pops the last entry, or finds the FIFO empty, go to IDLE. No underrun is flagged in DRAIN.
    - start and stop are ignored.
- dac_en is high for exactly one cycle per delivered sample and is never high in IDLE or PRIME.
- dac_data holds its last value in IDLE.
- start and stop arriving in the same cycle:
  - In IDLE, start wins.
  - In PRIME or RUN, stop wins.
- If a start arrives while not in IDLE, it is ignored and div_q is unchanged.
- underrun stays set until the next accepted start or rst.

Test Plan:
1. Reset, then idle. Required: dac_data = 0x800, dac_en = 0, busy = 0, s_ready = 1, underrun = 0.
2. Prefill 4 samples (0x000, 0x400, 0x800, 0xFFF), then start with div = 3. Required:
   - Enters RUN on the next cycle.
   - dac_en pulses 4, 8, 12 and 16 cycles after RUN entry.
   - dac_data takes the values in order 0x000, 0x400, 0x800, 0xFFF.
3. Continuous s_valid with a 12-bit incrementing ramp, div = 0. Required:
   - After PRIME, dac_en is high every cycle and dac_data increments by 1 per cycle.
   - s_ready never drops for more than 1 cycle; underrun stays 0.
4. Start with div = 1, feed 4 samples, then hold s_valid = 0. Required:
   - 4 dac_en pulses.
   - On the 5th tick: underrun = 1, dac_data holds the 4th sample, no dac_en.
   - A new start clears underrun.
5. stop during RUN with 3 entries queued. Required:
   - 3 further dac_en pulses at div spacing, then busy = 0.
   - Then IDLE with dac_data = last sample.
   - A start and stop pulsed in the same cycle while in PRIME returns to IDLE.
6. Assert rst mid-RUN with 2 entries queued. Required: next cycle state = IDLE, count = 0, dac_data = 0x800, dac_en = 0. Then start with an empty FIFO. Required: state stays in PRIME with no dac_en until 4 pushes arrive.
